// File: rtl/rot_slice_reader.sv
// Read-side scanner for the rotational frame buffer: on each slice request, walks every
// row of the current slice and hands each row to the LED driver over valid/ready.
module rot_slice_reader #(
    parameter  int ROTATIONAL_RES = 32,
    parameter  int ROWS           = 64,
    parameter  int READ_LATENCY   = 1,
    localparam int AW             = $clog2(ROWS * ROTATIONAL_RES),
    localparam int RW             = $clog2(ROWS),
    localparam int SW             = $clog2(ROTATIONAL_RES)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          index_pulse_in,
    input  logic          slice_tick_in,
    input  logic          overrun_clr_in,
    output logic [AW-1:0] addr_out,
    input  logic [63:0]   row_in,
    output logic [63:0]   row_data_out,
    output logic [RW-1:0] row_idx_out,
    output logic          row_valid_out,
    input  logic          row_ready_in,
    output logic [SW-1:0] slice_out,
    output logic          busy_out,
    output logic          scan_done_out,
    output logic          overrun_out
);

    localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} state_t;

    state_t        state;
    logic [SW-1:0] slice_ptr;
    logic          pending;
    logic [RW-1:0] row;
    logic [WW-1:0] wait_cnt;
    logic          ev;
    logic          take;

    assign ev   = index_pulse_in | slice_tick_in;
    assign take = (state == IDLE) & pending;

    function automatic logic [AW-1:0] row_addr(input logic [SW-1:0] s, input logic [RW-1:0] r);
        return AW'(s) * AW'(ROWS) + AW'(r);
    endfunction

    // Slice tracking and the 1-deep request flag; a request consumed this cycle still
    // counts as pending for overrun purposes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            slice_ptr   <= '0;
            pending     <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            if (index_pulse_in)
                slice_ptr <= '0;
            else if (slice_tick_in)
                slice_ptr <= (slice_ptr == SW'(ROTATIONAL_RES - 1)) ? '0 : slice_ptr + SW'(1);
            pending <= take ? 1'b0 : (pending | ev);
            if (ev && pending)
                overrun_out <= 1'b1;
            else if (overrun_clr_in)
                overrun_out <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            row           <= '0;
            wait_cnt      <= '0;
            addr_out      <= '0;
            row_data_out  <= '0;
            row_idx_out   <= '0;
            row_valid_out <= 1'b0;
            slice_out     <= '0;
            busy_out      <= 1'b0;
            scan_done_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending) begin
                        slice_out <= slice_ptr;
                        row       <= '0;
                        busy_out  <= 1'b1;
                        addr_out  <= row_addr(slice_ptr, '0);
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WW'(READ_LATENCY - 1)) begin
                        row_data_out  <= row_in;
                        row_idx_out   <= row;
                        row_valid_out <= 1'b1;
                        state         <= PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                PRESENT: begin
                    if (row_ready_in) begin
                        row_valid_out <= 1'b0;
                        if (row == RW'(ROWS - 1)) begin
                            scan_done_out <= 1'b1;
                            state         <= DONE;
                        end else begin
                            row      <= row + RW'(1);
                            addr_out <= row_addr(slice_out, row + RW'(1));
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    scan_done_out <= 1'b0;
                    busy_out      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_slice_reader.sv
// Bench for rot_slice_reader: directed scenarios plus random traffic, checked every cycle
// against an edge-time model of slice requests and row acceptance.
module tb_rot_slice_reader;

    localparam int RES  = 32;
    localparam int ROWS = 64;
    localparam int RL   = 1;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        idx = 0, tick = 0, clr = 0, ready = 0;
    logic [10:0] addr;
    logic [63:0] row_in, data;
    logic [5:0]  ridx;
    logic        vld, busy, done, ovr;
    logic [4:0]  slice;

    logic        idx3 = 0;
    logic [10:0] addr3;
    logic [63:0] row_in3, data3;
    logic [5:0]  ridx3;
    logic        vld3, busy3, done3, ovr3;
    logic [4:0]  slice3;
    logic [10:0] pipe3 [3];

    int checks = 0, errors = 0, n_done = 0;

    rot_slice_reader #(.ROTATIONAL_RES(RES), .ROWS(ROWS), .READ_LATENCY(RL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .index_pulse_in(idx), .slice_tick_in(tick),
        .overrun_clr_in(clr), .addr_out(addr), .row_in(row_in), .row_data_out(data),
        .row_idx_out(ridx), .row_valid_out(vld), .row_ready_in(ready), .slice_out(slice),
        .busy_out(busy), .scan_done_out(done), .overrun_out(ovr));

    rot_slice_reader #(.ROTATIONAL_RES(RES), .ROWS(ROWS), .READ_LATENCY(3)) dut3 (
        .clk_in(clk_in), .rst_in(rst_in), .index_pulse_in(idx3), .slice_tick_in(1'b0),
        .overrun_clr_in(1'b0), .addr_out(addr3), .row_in(row_in3), .row_data_out(data3),
        .row_idx_out(ridx3), .row_valid_out(vld3), .row_ready_in(1'b1), .slice_out(slice3),
        .busy_out(busy3), .scan_done_out(done3), .overrun_out(ovr3));

    // Frame buffer models: each word holds its own address
    always @(posedge clk_in) row_in <= 64'(addr);
    always @(posedge clk_in) begin
        pipe3[0] <= addr3;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign row_in3 = 64'(pipe3[2]);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: edge index of each expected event
    int cyc = 0, m_ptr = 0, m_slice = 0, m_row = 0, m_acc = 0, m_free = 0;
    bit m_pend = 0, m_ovr = 0, m_act = 0, m_busy = 0, m_done = 0;
    logic exp_v;
    assign exp_v = m_act && (cyc >= m_acc - 1);

    initial begin : model
        bit take, ev;
        forever begin
            @(posedge clk_in or negedge rst_in);
            if (!rst_in) begin
                cyc = 0; m_ptr = 0; m_slice = 0; m_row = 0; m_acc = 0; m_free = 0;
                m_pend = 0; m_ovr = 0; m_act = 0; m_busy = 0; m_done = 0;
            end else begin
                cyc++;
                take = !m_act && m_pend && (cyc >= m_free);
                ev   = idx || tick;
                if (ev && m_pend) m_ovr = 1;
                else if (clr) m_ovr = 0;
                m_pend = take ? 0 : (m_pend || ev);
                if (m_done) begin
                    m_done = 0;
                    m_busy = 0;
                end else if (m_act && cyc >= m_acc && ready) begin
                    if (m_row == ROWS - 1) begin
                        m_act  = 0;
                        m_done = 1;
                        m_free = cyc + 2;
                    end else begin
                        m_row++;
                        m_acc = cyc + 2 + RL;
                    end
                end
                if (take) begin
                    m_slice = m_ptr; m_row = 0; m_act = 1; m_busy = 1;
                    m_acc   = cyc + 2 + RL;
                end
                if (idx) m_ptr = 0;
                else if (tick) m_ptr = (m_ptr + 1) % RES;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                chk("valid", 64'(vld), 64'(exp_v));
                chk("busy", 64'(busy), 64'(m_busy));
                chk("done", 64'(done), 64'(m_done));
                chk("overrun", 64'(ovr), 64'(m_ovr));
                chk("slice", 64'(slice), 64'(m_slice));
                chk("addr", 64'(addr), 64'(m_slice * ROWS + m_row));
                if (exp_v) begin
                    chk("data", data, 64'(m_slice * ROWS + m_row));
                    chk("idx", 64'(ridx), 64'(m_row));
                end
                if (done) n_done++;
            end
        end
    end

    task automatic pulse(input logic i, input logic t);
        @(negedge clk_in); idx = i; tick = t;
        @(negedge clk_in); idx = 0; tick = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_act || m_busy || m_pend) && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        chk("idle_timeout", 64'(n < 2000), 64'(1));
    endtask

    task automatic scan_lat(input logic i, input logic t);
        int req, n;
        @(negedge clk_in); idx = i; tick = t; req = cyc;
        @(negedge clk_in); idx = 0; tick = 0;
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        chk("scan_latency", 64'(cyc - req), 64'(ROWS * (2 + RL) + 2));
        wait_idle();
    endtask

    initial begin : stim
        int n, k, prev, req, base;
        // Reset held: outputs stay zero whatever the inputs do
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            chk("rst_ctrl", 64'({addr, ridx, vld, busy, done, ovr, slice}), 64'(0));
            chk("rst_data", data, 64'(0));
            idx = 1'($urandom); tick = 1'($urandom); clr = 1'($urandom); ready = 1'($urandom);
        end
        @(negedge clk_in); idx = 0; tick = 0; clr = 0; ready = 1; rst_in = 1;
        repeat (5) @(negedge clk_in);

        scan_lat(1, 0);
        chk("scan1_slice", 64'(slice), 64'(0));
        scan_lat(0, 1);
        chk("scan2_slice", 64'(slice), 64'(1));

        // Read latency 3 variant
        @(negedge clk_in); idx3 = 1; req = cyc;
        @(negedge clk_in); idx3 = 0;
        k = 0; n = 0; prev = 0;
        while (!done3 && n < 1000) begin
            if (vld3) begin
                chk("l3_data", data3, 64'(k));
                chk("l3_idx", 64'(ridx3), 64'(k));
                if (k > 0) chk("l3_gap", 64'(cyc - prev), 64'(5));
                prev = cyc;
                k++;
            end
            @(negedge clk_in);
            n++;
        end
        chk("l3_rows", 64'(k), 64'(ROWS));
        chk("l3_latency", 64'(cyc - req), 64'(ROWS * 5 + 2));

        // Backpressure on row 10
        pulse(0, 1);
        n = 0;
        while (!(exp_v && m_row == 10) && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        chk("bp_reach", 64'(n < 500), 64'(1));
        ready = 0;
        base = m_slice * ROWS;
        repeat (5) begin
            @(negedge clk_in);
            chk("bp_valid", 64'(vld), 64'(1));
            chk("bp_data", data, 64'(base + 10));
            chk("bp_idx", 64'(ridx), 64'(10));
            chk("bp_addr", 64'(addr), 64'(base + 10));
        end
        ready = 1;
        wait_idle();

        // Slice wrap
        pulse(1, 0);
        wait_idle();
        for (int i = 0; i < 32; i++) begin
            pulse(0, 1);
            wait_idle();
            if (i == 30) chk("wrap_31", 64'(slice), 64'(31));
        end
        chk("wrap_0", 64'(slice), 64'(0));
        pulse(0, 1);
        wait_idle();
        k = n_done;
        pulse(1, 1);
        wait_idle();
        chk("both_slice", 64'(slice), 64'(0));
        chk("both_scans", 64'(n_done - k), 64'(1));

        // Overrun: two ticks during a scan
        k = n_done;
        pulse(0, 1);
        n = 0;
        while (!m_busy && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        pulse(0, 1);
        pulse(0, 1);
        chk("ovr_set", 64'(ovr), 64'(1));
        wait_idle();
        chk("ovr_slice", 64'(slice), 64'(3));
        chk("ovr_scans", 64'(n_done - k), 64'(2));
        chk("ovr_sticky", 64'(ovr), 64'(1));
        @(negedge clk_in); clr = 1;
        @(negedge clk_in); clr = 0;
        chk("ovr_clr", 64'(ovr), 64'(0));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_in);
            ready = ($urandom_range(0, 99) < 75);
            tick  = ($urandom_range(0, 199) == 0);
            idx   = ($urandom_range(0, 999) == 0);
            clr   = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk_in); ready = 1; tick = 0; idx = 0; clr = 0;
        wait_idle();

        // Asynchronous reset in the middle of row 20
        pulse(0, 1);
        n = 0;
        while (!(m_act && m_row == 20) && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        chk("rstm_reach", 64'(n < 500), 64'(1));
        @(posedge clk_in);
        #2 rst_in = 0;
        #1;
        chk("rstm_ctrl", 64'({addr, ridx, vld, busy, done, ovr, slice}), 64'(0));
        chk("rstm_data", data, 64'(0));
        repeat (3) @(negedge clk_in);
        rst_in = 1;
        repeat (10) begin
            @(negedge clk_in);
            chk("post_rst_idle", 64'(busy), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
